result_unloader: RTL and testbench

Drains systolic-array results back to the Raspberry Pi host over the 8-bit byte bus.
- Snapshots NUM_RESULTS results of RESULT_W bits on a one-cycle capture strobe.
- Streams the snapshot out one byte per transfer, with a byte address and a valid/ack handshake.
- Sits between the array accumulators and the host interface. It is the read-out counterpart of the weight/matrix loading path.

---
 rtl/tpu_pkg.sv | 14 +
 rtl/result_unloader.sv | 97 +++++++++
 tb/tb_result_unloader.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/tpu_pkg.sv
// Shared definitions for the TPU host-side load/unload paths.
// Byte-bus width and default frame size are common to both directions.
package tpu_pkg;

  localparam int unsigned HOST_BYTE_W     = 8;
  localparam int unsigned BYTES_PER_FRAME = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StSend = 2'd1,
    StDone = 2'd2
  } unload_state_e;

endpackage

// File: rtl/result_unloader.sv
// Snapshots a set of array results on a capture strobe and streams them to the host
// one byte per valid/ack transfer, result 0 first, least-significant byte first.
module result_unloader
  import tpu_pkg::*;
#(
  parameter int unsigned NUM_RESULTS = 4,
  parameter int unsigned RESULT_W    = 16,
  localparam int unsigned NBYTES     = NUM_RESULTS * RESULT_W / HOST_BYTE_W,
  localparam int unsigned AW         = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            res_valid,
  input  logic [NUM_RESULTS*RESULT_W-1:0] res_flat,
  input  logic                            rpi_ack,
  output logic [HOST_BYTE_W-1:0]          rpi_data,
  output logic [AW-1:0]                   rpi_addr,
  output logic                            rpi_valid,
  output logic                            busy,
  output logic                            frame_done,
  output logic                            overrun
);

  localparam int unsigned SnapW = NUM_RESULTS * RESULT_W;
  localparam logic [AW-1:0] LastIdx = AW'(NBYTES - 1);

  unload_state_e    state_q, state_d;
  logic [SnapW-1:0] snap_q, snap_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic             overrun_d;

  always_comb begin
    state_d   = state_q;
    snap_d    = snap_q;
    idx_d     = idx_q;
    overrun_d = overrun;
    unique case (state_q)
      StIdle, StDone: begin
        idx_d   = '0;
        state_d = StIdle;
        if (res_valid) begin
          snap_d  = res_flat;
          state_d = StSend;
        end
      end
      StSend: begin
        // A strobe mid-frame is dropped; the in-flight snapshot is never disturbed.
        if (res_valid) overrun_d = 1'b1;
        if (rpi_ack) begin
          if (idx_q == LastIdx) begin
            idx_d   = '0;
            state_d = StDone;
          end else begin
            idx_d = idx_q + AW'(1);
          end
        end
      end
      default: begin
        idx_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      snap_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      idx_q   <= idx_d;
    end
  end

  // Outputs are registered from next-state so the first byte appears one cycle after capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rpi_data   <= '0;
      rpi_addr   <= '0;
      rpi_valid  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      rpi_data   <= (state_d == StSend) ?
                    snap_d[int'(idx_d)*HOST_BYTE_W +: HOST_BYTE_W] : '0;
      rpi_addr   <= idx_d;
      rpi_valid  <= (state_d == StSend);
      busy       <= (state_d == StSend);
      frame_done <= (state_d == StDone);
      overrun    <= overrun_d;
    end
  end

endmodule

// File: tb/tb_result_unloader.sv
// Self-checking bench for result_unloader: frame-level reference model plus directed literals.
module tb_result_unloader;

  localparam int NB = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        res_valid = 1'b0;
  logic [63:0] res_flat = '0;
  logic        rpi_ack = 1'b0;
  logic [7:0]  rpi_data;
  logic [2:0]  rpi_addr;
  logic        rpi_valid, busy, frame_done, overrun;

  int n_cmp = 0;
  int n_bad = 0;

  result_unloader #(.NUM_RESULTS(4), .RESULT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .res_valid  (res_valid),
    .res_flat   (res_flat),
    .rpi_ack    (rpi_ack),
    .rpi_data   (rpi_data),
    .rpi_addr   (rpi_addr),
    .rpi_valid  (rpi_valid),
    .busy       (busy),
    .frame_done (frame_done),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: m_pos is the index of the byte on offer, -1 when nothing is on offer.
  logic [7:0] m_frame [NB];
  int         m_pos  = -1;
  logic       m_done = 1'b0;
  logic       m_over = 1'b0;

  always @(posedge clk or posedge rst) begin : model
    int   np;
    logic nd;
    if (rst) begin
      m_pos  <= -1;
      m_done <= 1'b0;
      m_over <= 1'b0;
    end else begin
      np = m_pos;
      nd = 1'b0;
      if (m_pos >= 0 && rpi_ack) begin
        if (m_pos == NB - 1) begin
          np = -1;
          nd = 1'b1;
        end else begin
          np = m_pos + 1;
        end
      end
      if (res_valid && m_pos >= 0) m_over <= 1'b1;
      if (res_valid && m_pos < 0) begin
        for (int k = 0; k < NB; k++) m_frame[k] <= res_flat[8*k +: 8];
        np = 0;
      end
      m_pos  <= np;
      m_done <= nd;
    end
  end

  always @(negedge clk) begin : compare
    logic sending;
    sending = (m_pos >= 0);
    chk("valid", 32'(rpi_valid), 32'(sending));
    chk("busy", 32'(busy), 32'(sending));
    chk("frame_done", 32'(frame_done), 32'(m_done));
    chk("overrun", 32'(overrun), 32'(m_over));
    chk("addr", 32'(rpi_addr), sending ? 32'(m_pos) : 32'd0);
    chk("data", 32'(rpi_data), sending ? 32'(m_frame[m_pos]) : 32'd0);
  end

  task automatic capture(input logic [63:0] d);
    @(posedge clk);
    #1 res_flat = d;
    res_valid = 1'b1;
    @(posedge clk);
    #1 res_valid = 1'b0;
  endtask

  logic [63:0] frame_a = {16'h8001, 16'h00FF, 16'hABCD, 16'h1234};
  logic [63:0] frame_b = {16'h0708, 16'h0506, 16'h0304, 16'h0102};
  logic [7:0]  exp_a [NB] = '{8'h34, 8'h12, 8'hCD, 8'hAB, 8'hFF, 8'h00, 8'h01, 8'h80};

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", 32'(rpi_valid), 32'd0);
    chk("rst_addr", 32'(rpi_addr), 32'd0);
    chk("rst_data", 32'(rpi_data), 32'd0);
    chk("rst_busy_done_ovr", {29'd0, busy, frame_done, overrun}, 32'd0);

    // Spurious ack while idle.
    rpi_ack = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_ack_valid", 32'(rpi_valid), 32'd0);
    chk("idle_ack_addr", 32'(rpi_addr), 32'd0);

    // Full frame, ack held high.
    capture(frame_a);
    for (int i = 0; i < NB; i++) begin
      @(negedge clk);
      chk("t1_addr", 32'(rpi_addr), 32'(i));
      chk("t1_data", 32'(rpi_data), 32'(exp_a[i]));
    end
    @(negedge clk);
    chk("t1_done", 32'(frame_done), 32'd1);
    chk("t1_done_valid", 32'(rpi_valid), 32'd0);

    // Stalled host at byte 2.
    capture(frame_a);
    for (int i = 0; i < NB; i++) begin
      @(negedge clk);
      chk("t2_addr", 32'(rpi_addr), 32'(i));
      chk("t2_data", 32'(rpi_data), 32'(exp_a[i]));
      if (i == 2) begin
        rpi_ack = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("t2_hold_addr", 32'(rpi_addr), 32'd2);
          chk("t2_hold_data", 32'(rpi_data), 32'hCD);
          chk("t2_hold_valid", 32'(rpi_valid), 32'd1);
        end
        rpi_ack = 1'b1;
      end
    end
    @(negedge clk);
    chk("t2_done", 32'(frame_done), 32'd1);

    // Re-capture in the frame_done cycle.
    res_flat  = frame_b;
    res_valid = 1'b1;
    @(negedge clk);
    res_valid = 1'b0;
    chk("t4_addr", 32'(rpi_addr), 32'd0);
    chk("t4_data", 32'(rpi_data), 32'h02);
    chk("t4_valid", 32'(rpi_valid), 32'd1);
    chk("t4_ovr", 32'(overrun), 32'd0);
    repeat (NB) @(negedge clk);
    chk("t4_done", 32'(frame_done), 32'd1);

    // Overrun at byte 4.
    capture(frame_a);
    for (int i = 0; i <= 4; i++) @(negedge clk);
    chk("t3_addr4", 32'(rpi_addr), 32'd4);
    res_flat  = frame_b;
    res_valid = 1'b1;
    @(negedge clk);
    res_valid = 1'b0;
    chk("t3_data5", 32'(rpi_data), 32'h00);
    chk("t3_ovr", 32'(overrun), 32'd1);
    @(negedge clk);
    chk("t3_data6", 32'(rpi_data), 32'h01);
    @(negedge clk);
    chk("t3_data7", 32'(rpi_data), 32'h80);
    @(negedge clk);
    chk("t3_done", 32'(frame_done), 32'd1);
    repeat (3) @(negedge clk);
    chk("t3_ovr_sticky", 32'(overrun), 32'd1);

    // Asynchronous reset mid-frame at byte 5.
    capture(frame_b);
    for (int i = 0; i <= 5; i++) @(negedge clk);
    chk("t5_addr5", 32'(rpi_addr), 32'd5);
    #2 rst = 1'b1;
    #1;
    chk("t5_async_valid", 32'(rpi_valid), 32'd0);
    chk("t5_async_busy", 32'(busy), 32'd0);
    chk("t5_async_ovr", 32'(overrun), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("t5_idle_valid", 32'(rpi_valid), 32'd0);

    // Fresh frame after reset starts cleanly at byte 0.
    capture(frame_b);
    @(negedge clk);
    chk("t5_new_addr", 32'(rpi_addr), 32'd0);
    chk("t5_new_data", 32'(rpi_data), 32'h02);
    repeat (NB + 2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
